// File: rtl/button_debouncer.sv
// Push-button conditioner: two-flop synchroniser, counter-based debounce FSM,
// registered level / press / release strobes and a one-shot long-press strobe.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  // state        | meaning
  // IDLE         | debounced level low, sync2 stable low
  // PRESS_WAIT   | sync2 went high, counting stable high samples
  // PRESSED      | debounced level high, hold timer running
  // RELEASE_WAIT | sync2 went low, counting stable low samples; hold timer keeps running

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_MAX  = HW'(LONG_PRESS_CYCLES);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic          sync1_q, sync2_q;
  state_t        state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d, hcnt_inc;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          long_hit;

  // Saturating hold counter; the one-shot comes from detecting the step onto H_MAX.
  assign hcnt_inc = (hcnt_q == H_MAX) ? hcnt_q : hcnt_q + HW'(1);
  assign long_hit = (hcnt_q != H_MAX) && (hcnt_inc == H_MAX);

  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    hcnt_d    = hcnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = PRESS_WAIT;
          dcnt_d  = DW'(1);
        end else begin
          dcnt_d  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = IDLE;
          dcnt_d  = '0;
        end else if (dcnt_q == D_LAST) begin
          state_d = PRESSED;
          level_d = 1'b1;
          press_d = 1'b1;
          hcnt_d  = '0;
          dcnt_d  = '0;
        end else begin
          dcnt_d  = dcnt_q + DW'(1);
        end
      end
      PRESSED: begin
        hcnt_d = hcnt_inc;
        long_d = long_hit;
        if (!sync2_q) begin
          state_d = RELEASE_WAIT;
          dcnt_d  = DW'(1);
        end
      end
      RELEASE_WAIT: begin
        hcnt_d = hcnt_inc;
        long_d = long_hit;
        if (sync2_q) begin
          state_d   = PRESSED;
          dcnt_d    = '0;
        end else if (dcnt_q == D_LAST) begin
          state_d   = IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
          dcnt_d    = '0;
        end else begin
          dcnt_d    = dcnt_q + DW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        dcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= IDLE;
      dcnt_q    <= '0;
      hcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      sync1_q   <= button;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      hcnt_q    <= hcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_press    = long_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: reference table, directed corner sequences and
// random bounce traffic checked against a run-length behavioural model.
module tb_button_debouncer;

  localparam int D = 4;
  localparam int L = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic button = 1'b0;
  logic btn_level, press_pulse, release_pulse, long_press;

  button_debouncer #(.DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L)) dut (
    .clk(clk), .rst(rst), .button(button),
    .btn_level(btn_level), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .long_press(long_press)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model: level flips once the two-edge-delayed input has
  // disagreed with it for D consecutive edges; long press fires L edges after
  // the press edge unless the release edge came strictly earlier.
  logic dly[$];
  int   m_edge, m_run, m_press_edge;
  logic m_level, m_armed, m_prs, m_rel, m_lng;

  task automatic m_reset();
    dly = {1'b0, 1'b0};
    m_edge = 0; m_run = 0; m_press_edge = 0;
    m_level = 0; m_armed = 0; m_prs = 0; m_rel = 0; m_lng = 0;
  endtask

  task automatic m_edge_step(input logic b);
    logic s;
    s = dly.pop_front();
    dly.push_back(b);
    m_edge++;
    m_prs = 0; m_rel = 0; m_lng = 0;
    if (m_armed && m_edge == m_press_edge + L) m_lng = 1;
    if (s != m_level) begin
      m_run++;
      if (m_run == D) begin
        m_level = s;
        m_run = 0;
        if (s) begin m_prs = 1; m_press_edge = m_edge; m_armed = 1; end
        else begin m_rel = 1; m_armed = 0; end
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic check_bits(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got(lvl,prs,rel,lng)=%b want=%b t=%0t", name, got, want, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  function automatic logic [3:0] outs();
    return {btn_level, press_pulse, release_pulse, long_press};
  endfunction

  // Per-segment observation of DUT strobes
  int idx, np, nr, nl, press_at, release_at, long_at, low_after_press;

  task automatic begin_seg();
    idx = 0; np = 0; nr = 0; nl = 0;
    press_at = -1; release_at = -1; long_at = -1; low_after_press = -1;
  endtask

  task automatic step(input logic b);
    button = b;
    @(posedge clk);
    m_edge_step(b);
    @(negedge clk);
    check_bits("model", outs(), {m_level, m_prs, m_rel, m_lng});
    if (press_pulse)   begin np++; press_at = idx; end
    if (release_pulse) begin nr++; release_at = idx; end
    if (long_press)    begin nl++; long_at = idx; end
    if (press_at >= 0 && !btn_level && low_after_press < 0) low_after_press = idx;
    idx++;
  endtask

  task automatic hold(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b);
  endtask

  typedef struct {
    logic b;
    logic lvl, prs, rel, lng;
  } vec_t;
  vec_t tbl[18];

  logic pat3[10] = '{1,0,1,1,0,1,1,1,1,1};
  logic pat5[7]  = '{0,0,1,0,0,0,0};

  initial begin
    for (int i = 0; i < 18; i++) begin
      tbl[i].b   = (i < 8);
      tbl[i].lvl = (i >= 5 && i < 13);
      tbl[i].prs = (i == 5);
      tbl[i].rel = (i == 13);
      tbl[i].lng = 1'b0;
    end
    m_reset();

    #10;
    check_bits("reset_state", outs(), 4'b0000);
    #10;
    rst = 1'b0;

    // 1: clean press, table driven
    begin_seg();
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].b);
      check_bits("table", outs(), {tbl[i].lvl, tbl[i].prs, tbl[i].rel, tbl[i].lng});
    end

    // 2: glitch of D-1 samples
    begin_seg();
    hold(1, 3);
    hold(0, 20);
    check_int("glitch_strobes", np + nr + nl, 0);
    check_int("glitch_level_rose", press_at, -1);

    // 3: bounce on press
    begin_seg();
    for (int i = 0; i < 10; i++) step(pat3[i]);
    hold(1, 10);
    hold(0, 12);
    check_int("bounce_press_count", np, 1);
    check_int("bounce_press_at", press_at, 10);

    // 4: long press
    begin_seg();
    hold(1, 40);
    hold(0, 15);
    check_int("long_press_at", press_at, 5);
    check_int("long_delay", long_at - press_at, L);
    check_int("long_count", nl, 1);
    check_int("long_release_at", release_at, 45);
    check_int("long_total_strobes", np + nr + nl, 3);

    // 5: release bounce
    begin_seg();
    hold(1, 10);
    for (int i = 0; i < 7; i++) step(pat5[i]);
    hold(0, 10);
    check_int("relb_press_count", np, 1);
    check_int("relb_release_count", nr, 1);
    check_int("relb_release_at", release_at, 18);
    check_int("relb_level_held", low_after_press, 18);
    check_int("relb_no_long", nl, 0);

    // 6: reset mid-press
    begin_seg();
    hold(1, 8);
    check_int("pre_rst_level", int'(btn_level), 1);
    rst = 1'b1;
    #1;
    check_bits("rst_async", outs(), 4'b0000);
    m_reset();
    repeat (2) @(negedge clk);
    check_bits("rst_held", outs(), 4'b0000);
    rst = 1'b0;
    begin_seg();
    hold(1, 10);
    check_int("post_rst_press_at", press_at, 5);
    check_int("post_rst_press_count", np, 1);
    hold(0, 12);

    // Random bouncing traffic against the model
    for (int s = 0; s < 80; s++) begin
      int len;
      logic lv;
      lv  = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(18, 30)) : int'($urandom_range(1, 7));
      hold(lv, len);
    end
    hold(0, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Front-end conditioning stage that sits directly upstream of the LED controller's `button` input. It synchronises the raw push-button pin into the `clk` domain and filters contact bounce with a counter-based state machine. Its registered outputs are:

- a debounced level;
- single-cycle press and release strobes;
- a single-cycle long-press strobe.

The LED controller's mode-step logic then sees exactly one event per physical press.

## Interface

**Parameters**

- `DEBOUNCE_CYCLES`, default 1000000: number of consecutive stable synchronised samples needed to accept a level change. Legal range is ≥ 2.
- `LONG_PRESS_CYCLES`, default 100000000: number of cycles the debounced level must stay high, counted from the press strobe, before the long-press strobe fires. Legal range is ≥ 1.

**Ports**

- `clk` input, 1 bit: system clock. This is the only clock.
- `rst` input, 1 bit: reset. Asynchronous, active-high.
- `button` input, 1 bit: raw, asynchronous, bouncing pin. Active-high.
- `btn_level` output, 1 bit: debounced level.
- `press_pulse` output, 1 bit: one-cycle strobe on an accepted press.
- `release_pulse` output, 1 bit: one-cycle strobe on an accepted release.
- `long_press` output, 1 bit: one-cycle strobe, at most once per press.

## Operation

**Synchroniser**
- Two flops: `button` → `sync1` → `sync2`.
- Only `sync2` is used downstream.

**Counters**
- Debounce counter `dcnt`: width `$clog2(DEBOUNCE_CYCLES+1)`.
- Hold counter `hcnt`: width `$clog2(LONG_PRESS_CYCLES+1)`. It saturates at `LONG_PRESS_CYCLES` and never wraps.

**FSM states:** IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.

- **IDLE**
  - If `sync2`=1: go to PRESS_WAIT with `dcnt`=1.
  - Otherwise stay in IDLE with `dcnt`=0.
- **PRESS_WAIT**
  - If `sync2`=0: return to IDLE with `dcnt`=0 (glitch rejected, no output activity).
  - Else if `dcnt`==`DEBOUNCE_CYCLES`−1: go to PRESSED. Set `btn_level`=1, pulse `press_pulse`, `hcnt`=0, `dcnt`=0.
  - Else: `dcnt`++.
- **PRESSED**
  - `hcnt`++ (saturating).
  - When `hcnt` transitions to `LONG_PRESS_CYCLES`, pulse `long_press`. It fires once only, because the saturated counter cannot re-trigger.
  - If `sync2`=0: go to RELEASE_WAIT with `dcnt`=1.
- **RELEASE_WAIT**
  - `hcnt` keeps counting, so a bounce does not restart long-press timing.
  - A long-press event falling in this state still fires.
  - If `sync2`=1: return to PRESSED with `dcnt`=0.
  - Else if `dcnt`==`DEBOUNCE_CYCLES`−1: go to IDLE. Set `btn_level`=0, pulse `release_pulse`, `dcnt`=0.
  - Else: `dcnt`++.

**Output rules**
- `press_pulse`, `release_pulse` and `long_press` are registered and high for exactly one cycle.
- `press_pulse` and `release_pulse` are never high in the same cycle.
- `long_press` may coincide with neither of the other two strobes except as described in the long-press notes above.

## Timing

- **Reset values:** `rst`=1 asynchronously forces the following. All outputs are held until `rst` deasserts.
  - `sync1`=0, `sync2`=0
  - state IDLE, `dcnt`=0, `hcnt`=0
  - `btn_level`=0, `press_pulse`=0, `release_pulse`=0, `long_press`=0
- **Press latency:**
  - Let E0 be the first clock edge at which `button`=1 is sampled, with `button` held high.
  - `btn_level` and `press_pulse` rise after edge E0+`DEBOUNCE_CYCLES`+1, i.e. `DEBOUNCE_CYCLES`+2 edges including E0.
  - `press_pulse` falls one edge later.
- **Release latency:** symmetric to press latency; `release_pulse` and `btn_level` fall after `DEBOUNCE_CYCLES`+2 edges.
- **Minimum accepted pulse:** `button` must be high for ≥ `DEBOUNCE_CYCLES` consecutive sampled edges. A high lasting `DEBOUNCE_CYCLES`−1 edges produces nothing.
- **Long press:** if `press_pulse` is high in cycle C, `long_press` is high in cycle C+`LONG_PRESS_CYCLES`, provided the release has not completed by then.
- **Release completing first:** if the release completes before `LONG_PRESS_CYCLES`, there is no `long_press`.
- **Reset mid-press:**
  - Outputs drop immediately.
  - If `button` is still held after `rst` deasserts, a fresh press is detected with full latency.
- **Simultaneous events:** in a cycle where the debounce threshold is met and `sync2` reverses in the same cycle, the reversal wins. The state returns to IDLE or PRESSED respectively and no strobe is issued.

## Test plan

Bench parameters: `DEBOUNCE_CYCLES`=4, `LONG_PRESS_CYCLES`=20, 10 ns clock, `rst` released at 20 ns.

1. **Clean press:** hold `button` high for 8 cycles, then low.
   - `press_pulse` is high for one cycle, 6 edges after the first high sample.
   - `btn_level` is high until `release_pulse` occurs, 6 edges after the first low sample.
   - `long_press` stays 0.
2. **Glitch rejection:** pulse `button` high for 3 cycles, then low for 20 cycles.
   - All outputs stay 0 throughout.
3. **Bounce on press:** drive the pattern 1,0,1,1,0,1,1,1,1,1 then hold high.
   - Exactly one `press_pulse`, 6 edges after the start of the final stable run.
4. **Long press:** hold high for 40 cycles.
   - `long_press` is high once, exactly 20 cycles after `press_pulse`.
   - One `release_pulse` follows the release.
   - Total strobe count is 3.
5. **Release bounce:** while pressed, drive the pattern 0,0,1,0,0,0,0 then hold low.
   - `btn_level` stays 1 through the bounce.
   - A single `release_pulse` occurs.
   - No second `press_pulse`.
6. **Reset mid-press:** assert `rst` for 2 cycles while `btn_level`=1 and `button` is still held.
   - All outputs are 0 immediately.
   - After `rst` deasserts, a new `press_pulse` occurs 6 edges later.
